mlaccel_mem_arbiter: RTL and testbench

- Owns the single 64-bit main memory port and shares it between three requesters:
  - compute (cmem): fixed-latency, never stalled;
  - host/SPI command path (qmem): 16-bit read/write;
  - sequencer instruction fetch (smem): 32-bit read.
- Fixed priority cmem > qmem > smem; one outstanding access each for qmem and smem.
- Registers the memory command and returns done/ready strobes at a fixed latency.
- Counts consecutive denied cycles per low-priority client and raises a sticky starvation flag.

---
 rtl/mlaccel_mem_arbiter_if.sv | 56 +++++
 rtl/mlaccel_mem_arbiter.sv | 113 +++++++++++
 tb/tb_mlaccel_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mlaccel_mem_arbiter_if.sv
// Main memory port bundle: compute, host and sequencer requesters plus the 64-bit memory side.
// The arbiter uses the slave modport; the requesters and memory model use the master modport.
interface mlaccel_mem_arbiter_if;
  logic        cmem_ren;
  logic [7:0]  cmem_wen;
  logic [15:0] cmem_addr;
  logic [63:0] cmem_wdata;
  logic [63:0] cmem_rdata;

  logic        qmem_read;
  logic [1:0]  qmem_write;
  logic [15:0] qmem_addr;
  logic [15:0] qmem_wdata;
  logic        qmem_done;
  logic [15:0] qmem_rdata;

  logic        smem_valid;
  logic [15:0] smem_addr;
  logic        smem_ready;
  logic [31:0] smem_data;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wen;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  logic        starve_q;
  logic        starve_s;
  logic        starve_clr;

  modport slave (
    input  cmem_ren, cmem_wen, cmem_addr, cmem_wdata,
    output cmem_rdata,
    input  qmem_read, qmem_write, qmem_addr, qmem_wdata,
    output qmem_done, qmem_rdata,
    input  smem_valid, smem_addr,
    output smem_ready, smem_data,
    output mem_addr, mem_wen, mem_wdata,
    input  mem_rdata,
    output starve_q, starve_s,
    input  starve_clr
  );

  modport master (
    output cmem_ren, cmem_wen, cmem_addr, cmem_wdata,
    input  cmem_rdata,
    output qmem_read, qmem_write, qmem_addr, qmem_wdata,
    input  qmem_done, qmem_rdata,
    output smem_valid, smem_addr,
    input  smem_ready, smem_data,
    input  mem_addr, mem_wen, mem_wdata,
    output mem_rdata,
    input  starve_q, starve_s,
    output starve_clr
  );
endinterface

// File: rtl/mlaccel_mem_arbiter.sv
// Fixed-priority (cmem > qmem > smem) arbiter for the 64-bit memory port; command registered one cycle after grant.
// qmem_done/smem_ready pulse RD_LAT cycles after grant; losers stay pending and are counted toward starvation flags.
module mlaccel_mem_arbiter #(
  parameter int RD_LAT       = 2,
  parameter int STARVE_LIMIT = 255,
  parameter int CNT_W        = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  mlaccel_mem_arbiter_if.slave    bus
);

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  wen;
    logic [63:0] wdata;
  } mem_cmd_t;

  logic              c_req, q_req, s_req;
  logic              q_busy, s_busy;
  logic              grant_q, grant_s;
  logic [RD_LAT-1:0] q_sr, s_sr, q_sr_nxt, s_sr_nxt;
  logic [CNT_W-1:0]  q_cnt, s_cnt, q_cnt_nxt, s_cnt_nxt;
  logic              q_hit, s_hit;
  logic              starve_q_r, starve_s_r;
  mem_cmd_t          cmd_nxt, cmd_r;

  // Pending-but-denied cycles accumulate; an in-flight client is waiting on itself, not starving.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                input logic req, input logic busy,
                                                input logic grant);
    if (!req || grant)
      return '0;
    if (busy || cnt == {CNT_W{1'b1}})
      return cnt;
    return cnt + CNT_W'(1);
  endfunction

  always_comb begin
    c_req   = bus.cmem_ren | (|bus.cmem_wen);
    q_req   = bus.qmem_read | (|bus.qmem_write);
    s_req   = bus.smem_valid;
    q_busy  = |q_sr;
    s_busy  = |s_sr;
    grant_q = !c_req && q_req && !q_busy;
    grant_s = !c_req && !grant_q && s_req && !s_busy;
  end

  always_comb begin
    cmd_nxt.addr  = bus.cmem_addr;
    cmd_nxt.wen   = bus.cmem_wen;
    cmd_nxt.wdata = bus.cmem_wdata;
    if (grant_q) begin
      cmd_nxt.addr  = bus.qmem_addr;
      cmd_nxt.wen   = {6'b0, bus.qmem_write};
      cmd_nxt.wdata = {48'b0, bus.qmem_wdata};
    end else if (grant_s) begin
      cmd_nxt.addr  = bus.smem_addr;
      cmd_nxt.wen   = 8'h00;
      cmd_nxt.wdata = 64'h0;
    end
  end

  always_comb begin
    q_sr_nxt    = q_sr << 1;
    q_sr_nxt[0] = grant_q;
    s_sr_nxt    = s_sr << 1;
    s_sr_nxt[0] = grant_s;
    q_cnt_nxt   = cnt_next(q_cnt, q_req, q_busy, grant_q);
    s_cnt_nxt   = cnt_next(s_cnt, s_req, s_busy, grant_s);
    q_hit       = q_cnt_nxt >= CNT_W'(STARVE_LIMIT);
    s_hit       = s_cnt_nxt >= CNT_W'(STARVE_LIMIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cmd_r      <= '0;
      q_sr       <= '0;
      s_sr       <= '0;
      q_cnt      <= '0;
      s_cnt      <= '0;
      starve_q_r <= 1'b0;
      starve_s_r <= 1'b0;
    end else begin
      cmd_r <= cmd_nxt;
      q_sr  <= q_sr_nxt;
      s_sr  <= s_sr_nxt;
      q_cnt <= q_cnt_nxt;
      s_cnt <= s_cnt_nxt;
      // A new starvation event takes precedence over a simultaneous clear.
      if (q_hit)
        starve_q_r <= 1'b1;
      else if (bus.starve_clr)
        starve_q_r <= 1'b0;
      if (s_hit)
        starve_s_r <= 1'b1;
      else if (bus.starve_clr)
        starve_s_r <= 1'b0;
    end
  end

  assign bus.mem_addr   = cmd_r.addr;
  assign bus.mem_wen    = cmd_r.wen;
  assign bus.mem_wdata  = cmd_r.wdata;
  assign bus.qmem_done  = q_sr[RD_LAT-1];
  assign bus.smem_ready = s_sr[RD_LAT-1];
  assign bus.cmem_rdata = bus.mem_rdata;
  assign bus.qmem_rdata = bus.mem_rdata[15:0];
  assign bus.smem_data  = bus.mem_rdata[31:0];
  assign bus.starve_q   = starve_q_r;
  assign bus.starve_s   = starve_s_r;

endmodule

// File: tb/tb_mlaccel_mem_arbiter.sv
// Directed bench for mlaccel_mem_arbiter: memory model returns a fixed word per address one cycle after mem_addr.
module tb_mlaccel_mem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  localparam logic [15:0] IDLE_ADDR = 16'h0099;

  mlaccel_mem_arbiter_if bus ();

  mlaccel_mem_arbiter #(.RD_LAT(2), .STARVE_LIMIT(255), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0040: return 64'h1122334455667788;
      16'h0020: return 64'h0123456789ABCDEF;
      16'h0022: return 64'hFEDCBA9876543210;
      default:  return {4{a}};
    endcase
  endfunction

  // Memory sees the registered address in grant+1 and answers in grant+2.
  always @(posedge clock) bus.mem_rdata <= mem_word(bus.mem_addr);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cmem_ren   = 1'b0;
    bus.cmem_wen   = 8'h00;
    bus.cmem_addr  = IDLE_ADDR;
    bus.cmem_wdata = 64'h0;
    bus.qmem_read  = 1'b0;
    bus.qmem_write = 2'b00;
    bus.qmem_addr  = 16'h0;
    bus.qmem_wdata = 16'h0;
    bus.smem_valid = 1'b0;
    bus.smem_addr  = 16'h0;
    bus.starve_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    checks++; if (bus.mem_wen !== 8'h00) begin errors++; $display("FAIL reset_mem_wen got=%h exp=00", bus.mem_wen); end
    checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", bus.mem_addr); end
    checks++; if (bus.mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_mem_wdata got=%h exp=0", bus.mem_wdata); end
    checks++; if ({bus.qmem_done, bus.smem_ready} !== 2'b00) begin errors++; $display("FAIL reset_strobes got=%b exp=00", {bus.qmem_done, bus.smem_ready}); end
    checks++; if ({bus.starve_q, bus.starve_s} !== 2'b00) begin errors++; $display("FAIL reset_starve got=%b exp=00", {bus.starve_q, bus.starve_s}); end
    reset = 1'b0;
    step();
    checks++; if (bus.mem_addr !== IDLE_ADDR) begin errors++; $display("FAIL idle_addr got=%h exp=%h", bus.mem_addr, IDLE_ADDR); end
  endtask

  task automatic test_qmem_write();
    bus.qmem_addr = 16'h0012; bus.qmem_write = 2'b11; bus.qmem_wdata = 16'hBEEF;
    step();
    checks++; if (bus.mem_addr !== 16'h0012) begin errors++; $display("FAIL qwr_addr got=%h exp=0012", bus.mem_addr); end
    checks++; if (bus.mem_wen !== 8'h03) begin errors++; $display("FAIL qwr_wen got=%h exp=03", bus.mem_wen); end
    checks++; if (bus.mem_wdata !== 64'h000000000000BEEF) begin errors++; $display("FAIL qwr_wdata got=%h exp=000000000000beef", bus.mem_wdata); end
    checks++; if (bus.qmem_done !== 1'b0) begin errors++; $display("FAIL qwr_done_early got=%b exp=0", bus.qmem_done); end
    step();
    checks++; if (bus.qmem_done !== 1'b1) begin errors++; $display("FAIL qwr_done got=%b exp=1", bus.qmem_done); end
    checks++; if (bus.mem_wen !== 8'h00) begin errors++; $display("FAIL qwr_no_regrant got=%h exp=00", bus.mem_wen); end
    bus.qmem_write = 2'b00;
    step();
    checks++; if (bus.qmem_done !== 1'b0) begin errors++; $display("FAIL qwr_done_pulse got=%b exp=0", bus.qmem_done); end
  endtask

  task automatic test_smem_fetch();
    bus.smem_valid = 1'b1; bus.smem_addr = 16'h0040;
    step();
    checks++; if (bus.mem_addr !== 16'h0040 || bus.mem_wen !== 8'h00) begin errors++; $display("FAIL sf_cmd got=%h/%h exp=0040/00", bus.mem_addr, bus.mem_wen); end
    step();
    checks++; if (bus.smem_ready !== 1'b1) begin errors++; $display("FAIL sf_ready got=%b exp=1", bus.smem_ready); end
    checks++; if (bus.smem_data !== 32'h55667788) begin errors++; $display("FAIL sf_data got=%h exp=55667788", bus.smem_data); end
    checks++; if (bus.mem_addr !== IDLE_ADDR) begin errors++; $display("FAIL sf_no_regrant got=%h exp=%h", bus.mem_addr, IDLE_ADDR); end
    bus.smem_valid = 1'b0;
    step();
    checks++; if (bus.smem_ready !== 1'b0) begin errors++; $display("FAIL sf_ready_pulse got=%b exp=0", bus.smem_ready); end
  endtask

  task automatic test_priority();
    bus.qmem_read = 1'b1; bus.qmem_addr = 16'h0020;
    bus.smem_valid = 1'b1; bus.smem_addr = 16'h0040;
    step();
    checks++; if (bus.mem_addr !== 16'h0020) begin errors++; $display("FAIL pri_q_first got=%h exp=0020", bus.mem_addr); end
    step();
    checks++; if (bus.mem_addr !== 16'h0040) begin errors++; $display("FAIL pri_s_second got=%h exp=0040", bus.mem_addr); end
    checks++; if ({bus.qmem_done, bus.smem_ready} !== 2'b10) begin errors++; $display("FAIL pri_t2_strobes got=%b exp=10", {bus.qmem_done, bus.smem_ready}); end
    checks++; if (bus.qmem_rdata !== 16'hCDEF) begin errors++; $display("FAIL pri_q_rdata got=%h exp=cdef", bus.qmem_rdata); end
    bus.qmem_read = 1'b0;
    step();
    checks++; if ({bus.qmem_done, bus.smem_ready} !== 2'b01) begin errors++; $display("FAIL pri_t3_strobes got=%b exp=01", {bus.qmem_done, bus.smem_ready}); end
    checks++; if (bus.smem_data !== 32'h55667788) begin errors++; $display("FAIL pri_s_data got=%h exp=55667788", bus.smem_data); end
    bus.smem_valid = 1'b0;
    step();
  endtask

  task automatic test_cmem_write();
    bus.cmem_wen = 8'hF0; bus.cmem_addr = 16'h0077; bus.cmem_wdata = 64'hA5A5_0000_5A5A_1111;
    bus.qmem_read = 1'b1; bus.qmem_addr = 16'h0020;
    step();
    checks++; if (bus.mem_wen !== 8'hF0 || bus.mem_addr !== 16'h0077 || bus.mem_wdata !== 64'hA5A5_0000_5A5A_1111) begin
      errors++; $display("FAIL cw_cmd got=%h/%h/%h exp=f0/0077/a5a500005a5a1111", bus.mem_wen, bus.mem_addr, bus.mem_wdata); end
    checks++; if (bus.cmem_rdata !== mem_word(IDLE_ADDR)) begin errors++; $display("FAIL cw_rdata_pass got=%h exp=%h", bus.cmem_rdata, mem_word(IDLE_ADDR)); end
    idle_inputs();
    bus.qmem_read = 1'b1; bus.qmem_addr = 16'h0020;
    step();
    checks++; if (bus.mem_addr !== 16'h0020) begin errors++; $display("FAIL cw_q_after got=%h exp=0020", bus.mem_addr); end
    step();
    bus.qmem_read = 1'b0;
    step();
  endtask

  task automatic test_cmem_preempt();
    bit bad_grant = 1'b0;
    bit s_flag    = 1'b0;
    bus.cmem_ren = 1'b1; bus.cmem_addr = 16'h0007;
    bus.qmem_read = 1'b1; bus.qmem_addr = 16'h0030;
    for (int i = 1; i <= 300; i++) begin
      step();
      if (bus.mem_addr !== 16'h0007 || bus.qmem_done !== 1'b0) bad_grant = 1'b1;
      if (bus.starve_s !== 1'b0) s_flag = 1'b1;
      if (i == 254) begin
        checks++; if (bus.starve_q !== 1'b0) begin errors++; $display("FAIL starve_early got=%b exp=0", bus.starve_q); end
      end
      if (i == 255) begin
        checks++; if (bus.starve_q !== 1'b1) begin errors++; $display("FAIL starve_set got=%b exp=1", bus.starve_q); end
      end
    end
    checks++; if (bad_grant) begin errors++; $display("FAIL preempt_qgrant got=1 exp=0"); end
    checks++; if (s_flag) begin errors++; $display("FAIL preempt_starve_s got=1 exp=0"); end
    bus.cmem_ren = 1'b0; bus.cmem_addr = IDLE_ADDR;
    step();
    checks++; if (bus.mem_addr !== 16'h0030 || bus.mem_wen !== 8'h00) begin errors++; $display("FAIL preempt_q_grant got=%h/%h exp=0030/00", bus.mem_addr, bus.mem_wen); end
    step();
    checks++; if (bus.qmem_done !== 1'b1) begin errors++; $display("FAIL preempt_q_done got=%b exp=1", bus.qmem_done); end
    bus.qmem_read = 1'b0;
    step();
    checks++; if (bus.starve_q !== 1'b1) begin errors++; $display("FAIL starve_sticky got=%b exp=1", bus.starve_q); end
    bus.starve_clr = 1'b1;
    step();
    bus.starve_clr = 1'b0;
    checks++; if (bus.starve_q !== 1'b0) begin errors++; $display("FAIL starve_clr got=%b exp=0", bus.starve_q); end
  endtask

  task automatic test_reset_mid_access();
    bus.qmem_write = 2'b01; bus.qmem_addr = 16'h0050; bus.qmem_wdata = 16'h1234;
    step();
    checks++; if (bus.mem_wen !== 8'h01) begin errors++; $display("FAIL rm_grant got=%h exp=01", bus.mem_wen); end
    reset = 1'b1;
    bus.qmem_write = 2'b00;
    step();
    checks++; if (bus.qmem_done !== 1'b0) begin errors++; $display("FAIL rm_done_dropped got=%b exp=0", bus.qmem_done); end
    checks++; if (bus.mem_wen !== 8'h00) begin errors++; $display("FAIL rm_wen got=%h exp=00", bus.mem_wen); end
    reset = 1'b0;
    step();
    checks++; if (bus.qmem_done !== 1'b0) begin errors++; $display("FAIL rm_done_late got=%b exp=0", bus.qmem_done); end
    bus.qmem_read = 1'b1; bus.qmem_addr = 16'h0020;
    step();
    checks++; if (bus.mem_addr !== 16'h0020) begin errors++; $display("FAIL rm_new_grant got=%h exp=0020", bus.mem_addr); end
    step();
    checks++; if (bus.qmem_done !== 1'b1 || bus.qmem_rdata !== 16'hCDEF) begin errors++; $display("FAIL rm_new_done got=%b/%h exp=1/cdef", bus.qmem_done, bus.qmem_rdata); end
    bus.qmem_read = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.qmem_read = 1'b1; bus.qmem_addr = 16'h0020;
    step();
    checks++; if (bus.mem_addr !== 16'h0020) begin errors++; $display("FAIL b2b_first got=%h exp=0020", bus.mem_addr); end
    step();
    checks++; if (bus.qmem_done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got=%b exp=1", bus.qmem_done); end
    step();
    checks++; if (bus.mem_addr !== IDLE_ADDR || bus.qmem_done !== 1'b0) begin errors++; $display("FAIL b2b_no_dup got=%h/%b exp=%h/0", bus.mem_addr, bus.qmem_done, IDLE_ADDR); end
    bus.qmem_addr = 16'h0022;
    step();
    checks++; if (bus.mem_addr !== 16'h0022) begin errors++; $display("FAIL b2b_second got=%h exp=0022", bus.mem_addr); end
    step();
    checks++; if (bus.qmem_done !== 1'b1 || bus.qmem_rdata !== 16'h3210) begin errors++; $display("FAIL b2b_done2 got=%b/%h exp=1/3210", bus.qmem_done, bus.qmem_rdata); end
    bus.qmem_read = 1'b0;
    step();
    checks++; if (bus.qmem_done !== 1'b0) begin errors++; $display("FAIL b2b_quiet got=%b exp=0", bus.qmem_done); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_qmem_write();
    test_smem_fetch();
    test_priority();
    test_cmem_write();
    test_cmem_preempt();
    test_reset_mid_access();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
